// File: rtl/fetch_decode.sv
// fetch_decode: upstream control stage for the J17 datapath.
// Fetches one 32-bit instruction per step from instruction memory at the
// datapath PC, decodes it into the datapath control bundle and issues a
// one-cycle dp_step enable so the datapath executes exactly one instruction
// per fetch.
//
// Ports:
//   clock, reset_n         processor clock (posedge), synchronous active-low reset
//   pc                     current PC from the datapath
//   imem_req/addr/ack/data instruction memory handshake
//   dp_step                datapath enable, one pulse per executed instruction
//   alucode..writecode     decoded control bundle, valid while dp_step is high
//   halted, trap           sticky status flags, cleared only by reset
//   retire_count           retired-instruction counter (RETIRE_COUNT_EN only)
//
// Optional build macro: RETIRE_COUNT_EN adds the retire_count output.
//
// state       | meaning
// ------------+------------------------------------------------------------
// FETCH_START | latch imem_addr from pc, raise imem_req, clear timeout
// FETCH       | wait for imem_ack, count idle cycles, trap on timeout
// DECODE      | register the control bundle from the captured word
// EXEC        | dp_step high, controls held for the datapath
// HALT        | absorbing until reset (halt instruction, illegal op, timeout)

module fetch_decode #(
  parameter int IMEM_AW       = 10,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [31:0]        pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_data,
  output logic               dp_step,
  output logic [4:0]         alucode,
  output logic [2:0]         op1,
  output logic               imControl,
  output logic               flag,
  output logic               flag1,
  output logic [20:0]        op2,
  output logic               regenable,
  output logic [1:0]         ramenable,
  output logic [2:0]         pcControl,
  output logic [1:0]         writecode,
  output logic               halted,
  output logic               trap
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0]        retire_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH_START,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] instr;
  logic [4:0]  tmo_cnt;
  logic [4:0]  tmo_inc;
  logic        tmo_hit;
  logic [4:0]  opcode;
  logic        is_alu, is_mov, is_ld, is_br, is_halt, is_nop, is_illegal;

  // Only the low address bits reach instruction memory.
  logic unused_pc;
  assign unused_pc = ^pc[31:IMEM_AW];

  assign tmo_inc = (tmo_cnt == 5'h1f) ? tmo_cnt : tmo_cnt + 5'd1;
  assign tmo_hit = (tmo_inc == 5'(FETCH_TIMEOUT));

  assign opcode     = instr[31:27];
  assign is_alu     = (opcode <= 5'h0B);
  assign is_mov     = (opcode == 5'h0C);
  assign is_ld      = (opcode == 5'h0D);
  assign is_br      = (opcode[4:3] == 2'b10);
  assign is_halt    = (opcode == 5'h1E);
  assign is_nop     = (opcode == 5'h1F);
  assign is_illegal = !(is_alu || is_mov || is_ld || is_br || is_halt || is_nop);

  assign dp_step = (state == S_EXEC);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH_START: state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack)     state_nxt = S_DECODE;
        else if (tmo_hit) state_nxt = S_HALT;
      end
      S_DECODE:      state_nxt = (is_halt || is_illegal) ? S_HALT : S_EXEC;
      S_EXEC:        state_nxt = S_FETCH_START;
      default:       state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_FETCH_START;
      instr     <= '0;
      tmo_cnt   <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      alucode   <= '0;
      op1       <= '0;
      imControl <= 1'b0;
      flag      <= 1'b0;
      flag1     <= 1'b0;
      op2       <= '0;
      regenable <= 1'b0;
      ramenable <= '0;
      pcControl <= '0;
      writecode <= '0;
      halted    <= 1'b0;
      trap      <= 1'b0;
    end else begin
      state <= state_nxt;
      // Enables are only ever high for the EXEC cycle that follows DECODE.
      regenable <= 1'b0;
      ramenable <= 2'b00;
      case (state)
        S_FETCH_START: begin
          imem_addr <= pc[IMEM_AW-1:0];
          imem_req  <= 1'b1;
          tmo_cnt   <= '0;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr    <= imem_data;
            imem_req <= 1'b0;
          end else begin
            tmo_cnt <= tmo_inc;
            if (tmo_hit) begin
              trap     <= 1'b1;
              halted   <= 1'b1;
              imem_req <= 1'b0;
            end
          end
        end
        S_DECODE: begin
          op1       <= instr[26:24];
          imControl <= instr[23];
          flag      <= instr[22];
          flag1     <= instr[21];
          op2       <= instr[20:0];
          alucode   <= is_alu ? opcode : 5'd0;
          pcControl <= is_br ? opcode[2:0] : 3'd0;
          writecode <= is_mov ? 2'd1 : 2'd0;
          regenable <= is_alu || is_mov || is_ld;
          ramenable <= is_ld ? 2'b01 : 2'b00;
          if (is_halt) halted <= 1'b1;
          if (is_illegal) begin
            trap   <= 1'b1;
            halted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RETIRE_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset_n)             retire_count <= '0;
    else if (state == S_EXEC) retire_count <= retire_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_decode.sv
module tb_fetch_decode;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc = '0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        dp_step;
  logic [4:0]  alucode;
  logic [2:0]  op1;
  logic        imControl, flag, flag1;
  logic [20:0] op2;
  logic        regenable;
  logic [1:0]  ramenable;
  logic [2:0]  pcControl;
  logic [1:0]  writecode;
  logic        halted, trap;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  fetch_decode #(.IMEM_AW(10), .FETCH_TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dp_step(dp_step), .alucode(alucode), .op1(op1), .imControl(imControl),
    .flag(flag), .flag1(flag1), .op2(op2), .regenable(regenable), .ramenable(ramenable),
    .pcControl(pcControl), .writecode(writecode), .halted(halted), .trap(trap)
`ifdef RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  alucode;
    logic [2:0]  op1;
    logic        imc;
    logic        flag;
    logic        flag1;
    logic [20:0] op2;
    logic        regenable;
    logic [1:0]  ramenable;
    logic [2:0]  pcControl;
    logic [1:0]  writecode;
  } ctl_t;

  ctl_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   step_cnt = 0;

  always @(posedge clock) if (dp_step === 1'b1) step_cnt <= step_cnt + 1;

  function automatic ctl_t obs();
    ctl_t o;
    o.alucode = alucode; o.op1 = op1; o.imc = imControl; o.flag = flag; o.flag1 = flag1;
    o.op2 = op2; o.regenable = regenable; o.ramenable = ramenable;
    o.pcControl = pcControl; o.writecode = writecode;
    return o;
  endfunction

  // Expected control bundle for an executed instruction word.
  function automatic ctl_t model(input logic [31:0] w);
    ctl_t e;
    logic [4:0] opc;
    e = '0;
    opc = w[31:27];
    e.op1 = w[26:24]; e.imc = w[23]; e.flag = w[22]; e.flag1 = w[21]; e.op2 = w[20:0];
    if (opc <= 5'h0B) begin
      e.alucode = opc; e.regenable = 1'b1;
    end else if (opc == 5'h0C) begin
      e.writecode = 2'd1; e.regenable = 1'b1;
    end else if (opc == 5'h0D) begin
      e.ramenable = 2'b01; e.regenable = 1'b1;
    end else if (opc >= 5'h10 && opc <= 5'h17) begin
      e.pcControl = opc[2:0];
    end
    return e;
  endfunction

  task automatic reset_dut();
    @(negedge clock);
    reset_n = 1'b0;
    imem_ack = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Waits (bounded) for imem_req, then acks with w for one cycle.
  // Returns on the negedge after the ack cycle.
  task automatic do_fetch(input logic [31:0] w);
    int k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (imem_req !== 1'b1) $display("FAIL fetch_req_wait: imem_req=%b after %0d cycles, required 1", imem_req, k);
    else n_pass++;
    imem_ack = 1'b1;
    imem_data = w;
    @(negedge clock);
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    ctl_t got;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    got = obs();
    n_checks++;
    if ({imem_req, imem_addr, dp_step, halted, trap, got} !== '0)
      $display("FAIL reset_outputs: req=%b addr=%h step=%b halted=%b trap=%b ctl=%h, required all 0",
               imem_req, imem_addr, dp_step, halted, trap, got);
    else n_pass++;
`ifdef RETIRE_COUNT_EN
    n_checks++;
    if (retire_count !== 32'd0) $display("FAIL reset_retire: got %0d required 0", retire_count);
    else n_pass++;
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    ctl_t exp_c, got;
    int k;
    pc = 32'h0;
    q.push_back(model(32'h0A800005));
    do_fetch(32'h0A800005);
    n_checks++;
    if (imem_addr !== 10'h000) $display("FAIL alu_addr: got %h required 000", imem_addr);
    else n_pass++;
    k = 1;
    while (dp_step !== 1'b1 && k < 8) begin @(negedge clock); k++; end
    n_checks++;
    if (dp_step !== 1'b1 || k != 2) $display("FAIL alu_step_latency: step=%b at %0d cycles after ack, required 2", dp_step, k);
    else n_pass++;
    exp_c = q.pop_front();
    got = obs();
    n_checks++;
    if (got !== exp_c) $display("FAIL alu_decode: got %h required %h", got, exp_c);
    else n_pass++;
    n_checks++;
    if (got.alucode !== 5'd1 || got.op1 !== 3'd2 || got.imc !== 1'b1 || got.op2 !== 21'd5 || got.regenable !== 1'b1)
      $display("FAIL alu_fields: alucode=%0d op1=%0d imc=%b op2=%0d regen=%b, required 1 2 1 5 1",
               got.alucode, got.op1, got.imc, got.op2, got.regenable);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (dp_step !== 1'b0 || regenable !== 1'b0) $display("FAIL alu_single_pulse: step=%b regen=%b required 0 0", dp_step, regenable);
    else n_pass++;
  endtask

  task automatic test_branch();
    ctl_t exp_c, got;
    int k, s0;
    pc = 32'h0000_1234;
    s0 = step_cnt;
    q.push_back(model(32'h88000000));
    do_fetch(32'h88000000);
    n_checks++;
    if (imem_addr !== 10'h234) $display("FAIL branch_addr: got %h required 234", imem_addr);
    else n_pass++;
    k = 1;
    while (dp_step !== 1'b1 && k < 8) begin @(negedge clock); k++; end
    n_checks++;
    if (dp_step !== 1'b1 || k != 2) $display("FAIL branch_step_latency: step=%b at %0d, required 2", dp_step, k);
    else n_pass++;
    exp_c = q.pop_front();
    got = obs();
    n_checks++;
    if (got !== exp_c || got.pcControl !== 3'd1 || got.regenable !== 1'b0)
      $display("FAIL branch_decode: got %h required %h", got, exp_c);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (step_cnt != s0 + 1) $display("FAIL branch_pulse_count: got %0d required 1", step_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_delayed_ack();
    ctl_t exp_c, got;
    int k, bad, s0;
    logic [9:0] a0;
    pc = 32'h0000_0040;
    s0 = step_cnt;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin @(negedge clock); k++; end
    a0 = imem_addr;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req !== 1'b1 || imem_addr !== a0 || dp_step !== 1'b0) bad++;
      @(negedge clock);
    end
    if (imem_req !== 1'b1 || imem_addr !== a0) bad++;
    n_checks++;
    if (bad != 0 || a0 !== 10'h040 || step_cnt != s0)
      $display("FAIL delay_hold: %0d bad cycles, addr=%h required 040 held, steps=%0d", bad, a0, step_cnt - s0);
    else n_pass++;
    q.push_back(model(32'h61000003));
    do_fetch(32'h61000003);
    k = 1;
    while (dp_step !== 1'b1 && k < 8) begin @(negedge clock); k++; end
    n_checks++;
    if (dp_step !== 1'b1 || k != 2) $display("FAIL delay_step_latency: step=%b at %0d, required 2", dp_step, k);
    else n_pass++;
    exp_c = q.pop_front();
    got = obs();
    n_checks++;
    if (got !== exp_c || got.writecode !== 2'd1) $display("FAIL delay_mov_decode: got %h required %h", got, exp_c);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3] = '{32'h68400007, 32'hF8000000, 32'h1B0FFFFF};
    ctl_t exp_c, got;
    int k;
    for (int i = 0; i < 3; i++) begin
      q.push_back(model(words[i]));
      do_fetch(words[i]);
      k = 1;
      while (dp_step !== 1'b1 && k < 8) begin @(negedge clock); k++; end
      exp_c = q.pop_front();
      got = obs();
      n_checks++;
      if (dp_step !== 1'b1 || k != 2 || got !== exp_c)
        $display("FAIL b2b_decode[%0d]: step=%b lat=%0d got %h required %h", i, dp_step, k, got, exp_c);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if (ramenable !== 2'b00 || regenable !== 1'b0) $display("FAIL b2b_enable_clear[%0d]: ram=%b reg=%b required 00 0", i, ramenable, regenable);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int k, s0;
    reset_dut();
    s0 = step_cnt;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (imem_req === 1'b1) k++;
      else if (k > 0) break;
    end
    n_checks++;
    if (k != 15) $display("FAIL timeout_req_cycles: got %0d required 15", k);
    else n_pass++;
    n_checks++;
    if (trap !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) $display("FAIL timeout_flags: trap=%b halted=%b req=%b required 1 1 0", trap, halted, imem_req);
    else n_pass++;
    imem_ack = 1'b1;
    imem_data = 32'hF8000000;
    repeat (5) @(negedge clock);
    imem_ack = 1'b0;
    n_checks++;
    if (step_cnt != s0 || halted !== 1'b1 || imem_req !== 1'b0) $display("FAIL timeout_late_ack: steps=%0d halted=%b req=%b required 0 1 0", step_cnt - s0, halted, imem_req);
    else n_pass++;
  endtask

  task automatic test_illegal_and_halt();
    int s0;
    reset_dut();
    s0 = step_cnt;
    do_fetch(32'h70000000);
    repeat (6) @(negedge clock);
    n_checks++;
    if (trap !== 1'b1 || halted !== 1'b1 || step_cnt != s0 || imem_req !== 1'b0)
      $display("FAIL illegal_op: trap=%b halted=%b steps=%0d req=%b required 1 1 0 0", trap, halted, step_cnt - s0, imem_req);
    else n_pass++;
    reset_dut();
    s0 = step_cnt;
    do_fetch(32'hF0000000);
    repeat (6) @(negedge clock);
    n_checks++;
    if (trap !== 1'b0 || halted !== 1'b1 || step_cnt != s0 || imem_req !== 1'b0)
      $display("FAIL halt_op: trap=%b halted=%b steps=%0d req=%b required 0 1 0 0", trap, halted, step_cnt - s0, imem_req);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    ctl_t exp_c, got;
    int k, s0;
    pc = 32'h0000_0055;
    reset_dut();
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin @(negedge clock); k++; end
    s0 = step_cnt;
    reset_n = 1'b0;
    imem_ack = 1'b1;
    imem_data = 32'h0A800005;
    @(negedge clock);
    got = obs();
    n_checks++;
    if ({imem_req, imem_addr, dp_step, halted, trap, got} !== '0)
      $display("FAIL midreset_outputs: req=%b addr=%h step=%b ctl=%h required all 0", imem_req, imem_addr, dp_step, got);
    else n_pass++;
    reset_n = 1'b1;
    imem_ack = 1'b0;
    @(negedge clock);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h055) $display("FAIL midreset_restart: req=%b addr=%h required 1 055", imem_req, imem_addr);
    else n_pass++;
    q.push_back(model(32'h61000003));
    do_fetch(32'h61000003);
    k = 1;
    while (dp_step !== 1'b1 && k < 8) begin @(negedge clock); k++; end
    exp_c = q.pop_front();
    got = obs();
    n_checks++;
    if (dp_step !== 1'b1 || got !== exp_c || step_cnt != s0)
      $display("FAIL midreset_discard: step=%b got %h required %h, early steps=%0d", dp_step, got, exp_c, step_cnt - s0);
    else n_pass++;
    @(negedge clock);
  endtask

`ifdef RETIRE_COUNT_EN
  task automatic test_retire_count();
    int k;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      do_fetch(32'hF8000000);
      k = 1;
      while (dp_step !== 1'b1 && k < 8) begin @(negedge clock); k++; end
      @(negedge clock);
    end
    n_checks++;
    if (retire_count !== 32'd3) $display("FAIL retire_count: got %0d required 3", retire_count);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_delayed_ack();
    test_back_to_back();
    test_timeout();
    test_illegal_and_halt();
    test_reset_mid_fetch();
`ifdef RETIRE_COUNT_EN
    test_retire_count();
`endif
    n_checks++;
    if (q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
